// File: rtl/dds_wave_gen.sv
// Phase-accumulator waveform generator: saw up/down, triangle or square from one accumulator.
// New configs queue in a one-entry pending slot and take effect only at a phase wrap.
module dds_wave_gen #(
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 16,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  // Config handshake: a transfer happens on any rising edge where cfg_valid && cfg_ready;
  // cfg_ready depends only on the pending slot, never on cfg_valid.
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic [1:0]        cfg_mode,
  input  logic [OUT_W-1:0]  cfg_duty,
  output logic [OUT_W-1:0]  wave_out,
  output logic              wave_valid,
  output logic              wrap
);

  typedef enum logic [1:0] {
    MODE_SAW_UP = 2'd0,
    MODE_SAW_DN = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SQUARE = 2'd3
  } mode_e;

  localparam logic [OUT_W-1:0] DUTY_RST = {1'b1, {(OUT_W-1){1'b0}}};

  logic [ACC_W-1:0]  r_acc;
  logic [STEP_W-1:0] r_step_a;
  mode_e             r_mode_a;
  logic [OUT_W-1:0]  r_duty_a;
  logic              r_pend_valid;
  logic [STEP_W-1:0] r_step_p;
  mode_e             r_mode_p;
  logic [OUT_W-1:0]  r_duty_p;
  logic [OUT_W-1:0]  r_wave_out;
  logic              r_wave_valid;
  logic              r_wrap;

  logic [ACC_W-1:0]  w_step_ext;
  logic [ACC_W:0]    w_sum;
  logic              w_carry;
  logic              w_transfer;
  logic              w_accept;
  logic [OUT_W-1:0]  w_phase;
  logic [OUT_W-1:0]  w_fold;
  logic [OUT_W-1:0]  w_sample;

  assign w_step_ext = ACC_W'(r_step_a);
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_step_ext};
  assign w_carry    = enable & w_sum[ACC_W];
  // An idle generator (step 0) never wraps, so it takes a pending config straight away.
  assign w_transfer = r_pend_valid & (w_carry | (r_step_a == '0));
  assign w_accept   = cfg_valid & ~r_pend_valid;
  assign cfg_ready  = ~r_pend_valid;

  assign w_phase = r_acc[ACC_W-1 -: OUT_W];
  assign w_fold  = {w_phase[OUT_W-2:0], 1'b0};

  always_comb begin
    w_sample = w_phase;
    case (r_mode_a)
      MODE_SAW_UP: w_sample = w_phase;
      MODE_SAW_DN: w_sample = ~w_phase;
      MODE_TRI:    w_sample = w_phase[OUT_W-1] ? ~w_fold : w_fold;
      MODE_SQUARE: w_sample = (w_phase < r_duty_a) ? '1 : '0;
      default:     w_sample = w_phase;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc        <= '0;
      r_step_a     <= '0;
      r_mode_a     <= MODE_SAW_UP;
      r_duty_a     <= DUTY_RST;
      r_pend_valid <= 1'b0;
      r_step_p     <= '0;
      r_mode_p     <= MODE_SAW_UP;
      r_duty_p     <= DUTY_RST;
      r_wave_out   <= '0;
      r_wave_valid <= 1'b0;
      r_wrap       <= 1'b0;
    end else begin
      // The accumulator always advances with the old step; a transfer only affects later edges.
      if (enable) begin
        r_acc      <= w_sum[ACC_W-1:0];
        r_wave_out <= w_sample;
      end
      r_wave_valid <= enable;
      r_wrap       <= w_carry;

      if (w_transfer) begin
        r_step_a     <= r_step_p;
        r_mode_a     <= r_mode_p;
        r_duty_a     <= r_duty_p;
        r_pend_valid <= 1'b0;
      end else if (w_accept) begin
        r_step_p     <= cfg_step;
        r_mode_p     <= mode_e'(cfg_mode);
        r_duty_p     <= cfg_duty;
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign wave_out   = r_wave_out;
  assign wave_valid = r_wave_valid;
  assign wrap       = r_wrap;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Bench for dds_wave_gen: directed scenarios plus random traffic, all outputs compared
// every cycle against an arithmetic model of phase, active config and pending slot.
module tb_dds_wave_gen;

  localparam int ACC_W  = 20;
  localparam int OUT_W  = 8;
  localparam int STEP_W = 16;
  localparam int unsigned ACC_MOD = 1 << ACC_W;
  localparam int unsigned OMAX    = (1 << OUT_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic              clk;
  logic              reset;
  logic              enable;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [STEP_W-1:0] cfg_step;
  logic [1:0]        cfg_mode;
  logic [OUT_W-1:0]  cfg_duty;
  logic [OUT_W-1:0]  wave_out;
  logic              wave_valid;
  logic              wrap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dds_wave_gen #(.ACC_W(ACC_W), .OUT_W(OUT_W), .STEP_W(STEP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_step   (cfg_step),
    .cfg_mode   (cfg_mode),
    .cfg_duty   (cfg_duty),
    .wave_out   (wave_out),
    .wave_valid (wave_valid),
    .wrap       (wrap)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_wrap = -1;
  int exp_period = 0;
  logic [OUT_W-1:0] exp_q[$];

  // Reference model: phase as a plain integer, configs as plain integers.
  int unsigned m_acc = 0, m_step = 0, m_mode = 0, m_duty = 128;
  int unsigned m_step_p = 0, m_mode_p = 0, m_duty_p = 128;
  bit m_pend = 0;
  int unsigned m_wave = 0;
  bit m_valid = 0;
  bit m_wrap = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned wave_of(int unsigned acc, int unsigned mode, int unsigned duty);
    int unsigned p = acc >> (ACC_W - OUT_W);
    case (mode)
      0:       return p;
      1:       return OMAX - p;
      2:       return (p <= OMAX / 2) ? 2 * p : 2 * (OMAX - p) + 1;
      default: return (p < duty) ? OMAX : 0;
    endcase
  endfunction

  // Advance the model by one edge, clock the DUT, then compare every output.
  task automatic tick();
    int unsigned nxt;
    bit carry;
    bit xfer;
    if (reset) begin
      m_acc = 0; m_step = 0; m_mode = 0; m_duty = 1 << (OUT_W - 1);
      m_pend = 0; m_wave = 0; m_valid = 0; m_wrap = 0;
    end else begin
      nxt   = m_acc + m_step;
      carry = enable && (nxt >= ACC_MOD);
      xfer  = m_pend && (carry || m_step == 0);
      if (enable) m_wave = wave_of(m_acc, m_mode, m_duty);
      m_valid = enable;
      m_wrap  = carry;
      if (enable) m_acc = nxt % ACC_MOD;
      if (xfer) begin
        m_step = m_step_p; m_mode = m_mode_p; m_duty = m_duty_p; m_pend = 0;
      end else if (cfg_valid && !m_pend) begin
        m_step_p = cfg_step; m_mode_p = cfg_mode; m_duty_p = cfg_duty; m_pend = 1;
      end
    end
    exp_q.push_back(OUT_W'(m_wave));
    @(posedge clk);
    #1;
    cyc++;
    check_val("wave_out", wave_out, exp_q.pop_front());
    check_val("wave_valid", wave_valid, m_valid);
    check_val("wrap", wrap, m_wrap);
    check_val("cfg_ready", cfg_ready, !m_pend);
    if (wrap === 1'b1) begin
      if (last_wrap >= 0 && exp_period != 0) check_val("wrap_period", cyc - last_wrap, exp_period);
      last_wrap = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cfg(input int unsigned step, input int unsigned mode, input int unsigned duty);
    bit done = 0;
    cfg_valid = 1'b1;
    cfg_step  = STEP_W'(step);
    cfg_mode  = 2'(mode);
    cfg_duty  = OUT_W'(duty);
    for (int i = 0; i < 4000 && !done; i++) begin
      done = !m_pend;
      tick();
    end
    if (!done) check_val("cfg_accept_timeout", 0, 1);
    cfg_valid = 1'b0;
    cfg_step  = STEP_W'($urandom);
    cfg_mode  = 2'($urandom);
    cfg_duty  = OUT_W'($urandom);
  endtask

  task automatic wait_model_wrap(input string tag);
    bit seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      tick();
      seen = m_wrap;
    end
    if (!seen) check_val(tag, 0, 1);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    run(n);
    reset = 1'b0;
    last_wrap = -1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int highs;
    reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
    cfg_step = '0; cfg_mode = '0; cfg_duty = '0;
    #2;

    do_reset(3);
    check_val("rst_wave_out", wave_out, 0);
    check_val("rst_cfg_ready", cfg_ready, 1);
    enable = 1'b1;
    run(20);

    // Idle load, saw up: ramp of 256 samples per period
    exp_period = 256;
    send_cfg(16'h1000, 0, 0);
    run(600);

    send_cfg(16'h1000, 1, 0);
    run(300);
    send_cfg(16'h1000, 2, 0);
    run(300);

    // Square at duty 0x40: one full period after the switching wrap
    send_cfg(16'h1000, 3, 8'h40);
    wait_model_wrap("square_wrap_timeout");
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (wave_out === 8'hFF) highs++;
    end
    check_val("square_high_count", highs, 64);

    // Coherent reload with a stalled second offer
    send_cfg(16'h1000, 0, 0);
    wait_model_wrap("reload_wrap_timeout");
    run(100);
    exp_period = 0;
    send_cfg(16'h2000, 0, 0);
    check_val("pend_blocks_ready", cfg_ready, 0);
    send_cfg(16'h0800, 0, 0);
    run(600);

    // Enable gaps at step 0x1000
    send_cfg(16'h1000, 0, 0);
    wait_model_wrap("gap_wrap_timeout");
    last_wrap = -1;
    exp_period = 512;
    for (int i = 0; i < 1100; i++) begin
      enable = ~enable;
      tick();
    end
    enable = 1'b1;
    exp_period = 0;

    // Reset with a config pending, then maximum step
    send_cfg(16'h3000, 1, 0);
    check_val("pend_before_reset", cfg_ready, 0);
    do_reset(1);
    check_val("reset_clears_pend", cfg_ready, 1);
    check_val("reset_wave_out", wave_out, 0);
    run(5);
    send_cfg(16'hFFFF, 0, 0);
    run(200);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      enable    = ($urandom_range(0, 9) != 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       cfg_step = '0;
        1:       cfg_step = 16'hFFFF;
        default: cfg_step = STEP_W'($urandom_range(16'h0400, 16'hFFFF));
      endcase
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_duty = OUT_W'($urandom_range(0, OMAX));
      reset    = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    cfg_valid = 1'b0;
    run(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
